// File: rtl/apb_ft_uart_mp.sv
// APB bridge to an FT245-style parallel FIFO interface, with RX/TX FIFOs and a level IRQ.
// Optional TX->RX loopback is built only when APB_FT_UART_LOOPBACK_EN is defined.
module apb_ft_uart_mp #(
  parameter int RX_FIFO_LOG2   = 3,
  parameter int TX_FIFO_LOG2   = 3,
  parameter int STROBE_CYCLES  = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PENABLE,
  input  logic        PSEL,
  input  logic        PWRITE,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  inout  wire  [7:0]  ft_data,
  input  logic        ft_nRXF,
  output logic        ft_nRD,
  input  logic        ft_nTXE,
  output logic        ft_nWR,
  output logic        IRQ
);
  // state    | meaning
  // IDLE     | strobes high, choose next direction
  // RD_STRB  | ft_nRD low, byte captured on last cycle
  // RD_RCV   | strobes high, read recovery gap
  // WR_SETUP | TX head on ft_data, ft_nWR still high
  // WR_STRB  | ft_nWR low, TX popped on last cycle
  // WR_RCV   | strobes high, write recovery gap
  typedef enum logic [2:0] {IDLE, RD_STRB, RD_RCV, WR_SETUP, WR_STRB, WR_RCV} ft_state_t;

  localparam int RX_DEPTH = 1 << RX_FIFO_LOG2;
  localparam int TX_DEPTH = 1 << TX_FIFO_LOG2;
  localparam logic [3:0] STRB_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] RCV_LD  = 4'(RECOVER_CYCLES - 1);

  typedef logic [RX_FIFO_LOG2-1:0] rx_ptr_t;
  typedef logic [RX_FIFO_LOG2:0]   rx_lvl_t;
  typedef logic [TX_FIFO_LOG2-1:0] tx_ptr_t;
  typedef logic [TX_FIFO_LOG2:0]   tx_lvl_t;

  logic [7:0] rx_mem [RX_DEPTH];
  logic [7:0] tx_mem [TX_DEPTH];
  rx_ptr_t    rx_wp, rx_rp;
  tx_ptr_t    tx_wp, tx_rp;
  rx_lvl_t    rx_level;
  tx_lvl_t    tx_level;

  logic       rx_full, rx_not_empty, tx_full, tx_empty, rx_ge_thresh;
  logic [7:0] rx_head, tx_head;
  logic       rx_push, rx_pop, tx_push, tx_pop;
  logic [7:0] rx_push_data;
  logic       rx_push_fsm, tx_pop_fsm;
  logic       loop_hold, loop_move;

  logic       apb_acc, apb_wr, apb_rd;
  logic       sel_data, sel_status, sel_ctrl;
  logic       tx_push_req;
  logic       tx_drop;
  logic [2:0] ctrl_en;
  logic [7:0] rx_thresh;
  logic [31:0] ctrl_rd;

  logic [1:0] nrxf_sync, ntxe_sync;
  ft_state_t  state, state_nxt;
  logic [3:0] cnt;
  logic       last_rx;
  logic       drv_en;
  logic       rx_elig, tx_elig;
  logic       unused_ok;

  assign unused_ok = ^{PADDR[1:0], PWDATA[31:16]};

  // FIFO status; level MSB set only when the level equals the depth
  assign rx_full      = rx_level[RX_FIFO_LOG2];
  assign tx_full      = tx_level[TX_FIFO_LOG2];
  assign rx_not_empty = (rx_level != '0);
  assign tx_empty     = (tx_level == '0);
  assign rx_ge_thresh = (8'(rx_level) >= rx_thresh);
  assign rx_head      = rx_mem[rx_rp];
  assign tx_head      = tx_mem[tx_rp];

  assign apb_acc    = PSEL & PENABLE;
  assign apb_wr     = apb_acc & PWRITE;
  assign apb_rd     = apb_acc & ~PWRITE;
  assign sel_data   = (PADDR[3:2] == 2'd0);
  assign sel_status = (PADDR[3:2] == 2'd1);
  assign sel_ctrl   = (PADDR[3:2] == 2'd2);

  assign tx_push_req  = apb_wr & sel_data;
  assign tx_push      = tx_push_req & ~tx_full;
  assign rx_pop       = apb_rd & sel_data & rx_not_empty;
  assign rx_push      = rx_push_fsm | loop_move;
  assign tx_pop       = tx_pop_fsm | loop_move;
  assign rx_push_data = loop_move ? tx_head : ft_data;

`ifdef APB_FT_UART_LOOPBACK_EN
  logic ctrl_loop;

  always_ff @(posedge clk) begin
    if (reset) ctrl_loop <= 1'b0;
    else if (apb_wr && sel_ctrl) ctrl_loop <= PWDATA[3];
  end

  assign loop_hold = ctrl_loop;
  assign loop_move = ctrl_loop && (state == IDLE) && !tx_empty && !rx_full;
  assign ctrl_rd   = {16'b0, rx_thresh, 4'b0, ctrl_loop, ctrl_en};
`else
  assign loop_hold = 1'b0;
  assign loop_move = 1'b0;
  assign ctrl_rd   = {16'b0, rx_thresh, 5'b0, ctrl_en};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en   <= '0;
      rx_thresh <= '0;
      tx_drop   <= 1'b0;
      IRQ       <= 1'b0;
    end else begin
      if (apb_wr && sel_ctrl) begin
        ctrl_en   <= PWDATA[2:0];
        rx_thresh <= PWDATA[15:8];
      end
      if (tx_push_req && tx_full) tx_drop <= 1'b1;
      else if (apb_wr && sel_status && PWDATA[4]) tx_drop <= 1'b0;
      IRQ <= (ctrl_en[0] && rx_ge_thresh && rx_not_empty) ||
             (ctrl_en[1] && tx_empty) || (ctrl_en[2] && tx_drop);
    end
  end

  always_comb begin
    PRDATA = '0;
    if (apb_acc) begin
      case (PADDR[3:2])
        2'd0: PRDATA = rx_not_empty ? {23'b0, 1'b1, rx_head} : 32'b0;
        2'd1: PRDATA = {8'b0, 8'(tx_level), 8'(rx_level), 3'b0, tx_drop, tx_empty,
                        rx_ge_thresh, ~tx_full, rx_not_empty};
        2'd2: PRDATA = ctrl_rd;
        default: PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && rx_push) rx_mem[rx_wp] <= rx_push_data;
    if (!reset && tx_push) tx_mem[tx_wp] <= PWDATA[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wp <= '0; rx_rp <= '0; rx_level <= '0;
      tx_wp <= '0; tx_rp <= '0; tx_level <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_ptr_t'(rx_wp + 1'b1);
      if (rx_pop)  rx_rp <= rx_ptr_t'(rx_rp + 1'b1);
      if (rx_push && !rx_pop)      rx_level <= rx_lvl_t'(rx_level + 1'b1);
      else if (!rx_push && rx_pop) rx_level <= rx_lvl_t'(rx_level - 1'b1);
      if (tx_push) tx_wp <= tx_ptr_t'(tx_wp + 1'b1);
      if (tx_pop)  tx_rp <= tx_ptr_t'(tx_rp + 1'b1);
      if (tx_push && !tx_pop)      tx_level <= tx_lvl_t'(tx_level + 1'b1);
      else if (!tx_push && tx_pop) tx_level <= tx_lvl_t'(tx_level - 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nrxf_sync <= 2'b11;
      ntxe_sync <= 2'b11;
    end else begin
      nrxf_sync <= {nrxf_sync[0], ft_nRXF};
      ntxe_sync <= {ntxe_sync[0], ft_nTXE};
    end
  end

  assign rx_elig = !nrxf_sync[1] && !rx_full;
  assign tx_elig = !ntxe_sync[1] && !tx_empty;

  always_comb begin
    state_nxt   = state;
    rx_push_fsm = 1'b0;
    tx_pop_fsm  = 1'b0;
    case (state)
      IDLE: begin
        if (!loop_hold) begin
          if (rx_elig && (!tx_elig || !last_rx)) state_nxt = RD_STRB;
          else if (tx_elig)                      state_nxt = WR_SETUP;
        end
      end
      RD_STRB: if (cnt == '0) begin
        state_nxt   = RD_RCV;
        rx_push_fsm = 1'b1;
      end
      RD_RCV:   if (cnt == '0) state_nxt = IDLE;
      WR_SETUP: state_nxt = WR_STRB;
      WR_STRB: if (cnt == '0) begin
        state_nxt  = WR_RCV;
        tx_pop_fsm = 1'b1;
      end
      WR_RCV:   if (cnt == '0) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Strobes and data enable are registered from the next state so they change
  // cleanly at the edge, including the edge where reset lands mid-strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      last_rx <= 1'b0;
      ft_nRD  <= 1'b1;
      ft_nWR  <= 1'b1;
      drv_en  <= 1'b0;
    end else begin
      state  <= state_nxt;
      ft_nRD <= (state_nxt != RD_STRB);
      ft_nWR <= (state_nxt != WR_STRB);
      drv_en <= (state_nxt == WR_SETUP) || (state_nxt == WR_STRB);
      if (state == IDLE && state_nxt == RD_STRB)  last_rx <= 1'b1;
      if (state == IDLE && state_nxt == WR_SETUP) last_rx <= 1'b0;
      if (state_nxt != state) begin
        case (state_nxt)
          RD_STRB, WR_STRB: cnt <= STRB_LD;
          RD_RCV, WR_RCV:   cnt <= RCV_LD;
          default:          cnt <= '0;
        endcase
      end else if (cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign ft_data = drv_en ? tx_head : 8'hzz;

endmodule
